// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the 5-stage integer core: per-stage write enables and flushes
// covering load-use, CSR read-after-write, multi-cycle mul/div, data-memory wait and branch redirect.
module pipeline_hazard_ctrl #(
    parameter int CSR_DRAIN_CYCLES = 2,
    parameter int STALL_CNT_W      = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [4:0]             ifid_rs1,
    input  logic [4:0]             ifid_rs2,
    input  logic                   ifid_uses_rs1,
    input  logic                   ifid_uses_rs2,
    input  logic                   ifid_csr_read,
    input  logic [4:0]             idex_rd,
    input  logic                   idex_memread,
    input  logic                   idex_muldiv,
    input  logic                   muldiv_done,
    input  logic                   idex_csr_write,
    input  logic                   exmem_csr_write,
    input  logic                   memwb_csr_write,
    input  logic                   branch_taken,
    input  logic                   dmem_req,
    input  logic                   dmem_ready,
    output logic                   pc_write_en,
    output logic                   ifid_write_en,
    output logic                   idex_write_en,
    output logic                   exmem_write_en,
    output logic                   ifid_flush,
    output logic                   idex_flush,
    output logic                   exmem_flush,
    output logic                   memwb_flush,
    output logic [STALL_CNT_W-1:0] stall_cycles,
    output logic [1:0]             ctrl_state
);

    localparam logic [1:0] RUN       = 2'd0;
    localparam logic [1:0] MEM_WAIT  = 2'd1;
    localparam logic [1:0] MD_WAIT   = 2'd2;
    localparam logic [1:0] CSR_DRAIN = 2'd3;

    // Output actions; CSR entry and load-use share outputs but differ in next state.
    localparam logic [2:0] ACT_NONE = 3'd0;
    localparam logic [2:0] ACT_MEM  = 3'd1;
    localparam logic [2:0] ACT_MD   = 3'd2;
    localparam logic [2:0] ACT_BR   = 3'd3;
    localparam logic [2:0] ACT_CSR  = 3'd4;
    localparam logic [2:0] ACT_BUB  = 3'd5;

    localparam int DRAIN_W = (CSR_DRAIN_CYCLES > 1) ? $clog2(CSR_DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(CSR_DRAIN_CYCLES - 1);

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [DRAIN_W-1:0] drain_nxt;
    logic [2:0]         run_act;
    logic [2:0]         act;
    logic               hold;
    logic               mem_stall;
    logic               md_stall;
    logic               any_csr_write;
    logic               csr_hazard;
    logic               load_use;

    assign mem_stall     = dmem_req & ~dmem_ready;
    assign md_stall      = idex_muldiv & ~muldiv_done;
    assign any_csr_write = idex_csr_write | exmem_csr_write | memwb_csr_write;
    assign csr_hazard    = ifid_csr_read & any_csr_write;
    assign load_use      = idex_memread & (idex_rd != 5'd0) &
                           ((ifid_uses_rs1 & (ifid_rs1 == idex_rd)) |
                            (ifid_uses_rs2 & (ifid_rs2 == idex_rd)));

    always_comb begin
        run_act = ACT_NONE;
        if (mem_stall)
            run_act = ACT_MEM;
        else if (md_stall)
            run_act = ACT_MD;
        else if (branch_taken)
            run_act = ACT_BR;
        else if (csr_hazard)
            run_act = ACT_CSR;
        else if (load_use)
            run_act = ACT_BUB;
    end

    // Wait states either hold their freeze or fall through to the RUN decision this cycle.
    always_comb begin
        act       = run_act;
        hold      = 1'b0;
        state_nxt = RUN;
        drain_nxt = drain_cnt;
        case (state)
            MEM_WAIT: begin
                if (!dmem_ready) begin
                    act  = ACT_MEM;
                    hold = 1'b1;
                end
            end
            MD_WAIT: begin
                if (!mem_stall && !muldiv_done) begin
                    act  = ACT_MD;
                    hold = 1'b1;
                end
            end
            CSR_DRAIN: begin
                drain_nxt = (drain_cnt != '0) ? drain_cnt - DRAIN_W'(1) : '0;
                if (mem_stall) begin
                    act  = ACT_MEM;
                    hold = 1'b1;
                end else if ((drain_cnt != '0) || any_csr_write) begin
                    act  = ACT_BUB;
                    hold = 1'b1;
                end
            end
            default: ;
        endcase
        if (hold) begin
            state_nxt = state;
        end else begin
            case (act)
                ACT_MEM: state_nxt = MEM_WAIT;
                ACT_MD:  state_nxt = MD_WAIT;
                ACT_CSR: begin
                    state_nxt = CSR_DRAIN;
                    drain_nxt = DRAIN_LOAD;
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_comb begin
        pc_write_en    = 1'b1;
        ifid_write_en  = 1'b1;
        idex_write_en  = 1'b1;
        exmem_write_en = 1'b1;
        ifid_flush     = 1'b0;
        idex_flush     = 1'b0;
        exmem_flush    = 1'b0;
        memwb_flush    = 1'b0;
        if (reset) begin
            pc_write_en    = 1'b0;
            ifid_write_en  = 1'b0;
            idex_write_en  = 1'b0;
            exmem_write_en = 1'b0;
            ifid_flush     = 1'b1;
            idex_flush     = 1'b1;
            exmem_flush    = 1'b1;
            memwb_flush    = 1'b1;
        end else begin
            case (act)
                ACT_MEM: begin
                    pc_write_en    = 1'b0;
                    ifid_write_en  = 1'b0;
                    idex_write_en  = 1'b0;
                    exmem_write_en = 1'b0;
                    memwb_flush    = 1'b1;
                end
                ACT_MD: begin
                    pc_write_en   = 1'b0;
                    ifid_write_en = 1'b0;
                    idex_write_en = 1'b0;
                    exmem_flush   = 1'b1;
                end
                ACT_BR: begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end
                ACT_CSR, ACT_BUB: begin
                    pc_write_en   = 1'b0;
                    ifid_write_en = 1'b0;
                    idex_flush    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= RUN;
            drain_cnt    <= '0;
            stall_cycles <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
            if (!pc_write_en && (stall_cycles != {STALL_CNT_W{1'b1}}))
                stall_cycles <= stall_cycles + STALL_CNT_W'(1);
        end
    end

    assign ctrl_state = state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios, a rule-level reference model checked
// every cycle, and literal spot checks including a narrow-counter instance for saturation.
module tb_pipeline_hazard_ctrl;

    logic clock = 1'b0;
    logic reset;
    logic [4:0] ifid_rs1, ifid_rs2, idex_rd;
    logic ifid_uses_rs1, ifid_uses_rs2, ifid_csr_read;
    logic idex_memread, idex_muldiv, muldiv_done;
    logic idex_csr_write, exmem_csr_write, memwb_csr_write;
    logic branch_taken, dmem_req, dmem_ready;

    logic pc_write_en, ifid_write_en, idex_write_en, exmem_write_en;
    logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic [31:0] stall_cycles;
    logic [1:0] ctrl_state;

    logic s_pc, s_ifid, s_idex, s_exmem, s_fifid, s_fidex, s_fexmem, s_fmemwb;
    logic [2:0] s_stall;
    logic [1:0] s_state;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    int     m_mode;
    int     m_drain;
    longint m_stall;

    localparam int CSR_DRAIN = 2;
    localparam logic [7:0] O_RUN = 8'b1111_0000;
    localparam logic [7:0] O_MEM = 8'b0000_0001;
    localparam logic [7:0] O_MD  = 8'b0001_0010;
    localparam logic [7:0] O_BR  = 8'b1111_1100;
    localparam logic [7:0] O_BUB = 8'b0011_0100;
    localparam logic [7:0] O_RST = 8'b0000_1111;

    always #5 clock = ~clock;

    pipeline_hazard_ctrl #(.CSR_DRAIN_CYCLES(CSR_DRAIN), .STALL_CNT_W(32)) dut (
        .clock(clock), .reset(reset),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .ifid_uses_rs1(ifid_uses_rs1), .ifid_uses_rs2(ifid_uses_rs2),
        .ifid_csr_read(ifid_csr_read), .idex_rd(idex_rd),
        .idex_memread(idex_memread), .idex_muldiv(idex_muldiv), .muldiv_done(muldiv_done),
        .idex_csr_write(idex_csr_write), .exmem_csr_write(exmem_csr_write),
        .memwb_csr_write(memwb_csr_write), .branch_taken(branch_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write_en(pc_write_en), .ifid_write_en(ifid_write_en),
        .idex_write_en(idex_write_en), .exmem_write_en(exmem_write_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
        .stall_cycles(stall_cycles), .ctrl_state(ctrl_state)
    );

    pipeline_hazard_ctrl #(.CSR_DRAIN_CYCLES(CSR_DRAIN), .STALL_CNT_W(3)) dut_sat (
        .clock(clock), .reset(reset),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .ifid_uses_rs1(ifid_uses_rs1), .ifid_uses_rs2(ifid_uses_rs2),
        .ifid_csr_read(ifid_csr_read), .idex_rd(idex_rd),
        .idex_memread(idex_memread), .idex_muldiv(idex_muldiv), .muldiv_done(muldiv_done),
        .idex_csr_write(idex_csr_write), .exmem_csr_write(exmem_csr_write),
        .memwb_csr_write(memwb_csr_write), .branch_taken(branch_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write_en(s_pc), .ifid_write_en(s_ifid),
        .idex_write_en(s_idex), .exmem_write_en(s_exmem),
        .ifid_flush(s_fifid), .idex_flush(s_fidex),
        .exmem_flush(s_fexmem), .memwb_flush(s_fmemwb),
        .stall_cycles(s_stall), .ctrl_state(s_state)
    );

    task automatic cmp(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference: which rule governs this cycle, and which mode follows.
    function automatic void model_eval(output logic [7:0] o, output int nmode, output int ndrain);
        bit r1, r2, r4, r5, anyw;
        logic [7:0] run_o;
        int run_mode, run_drain;
        anyw = idex_csr_write || exmem_csr_write || memwb_csr_write;
        r1 = dmem_req && !dmem_ready;
        r2 = idex_muldiv && !muldiv_done;
        r4 = ifid_csr_read && anyw;
        r5 = idex_memread && (idex_rd != 0) &&
             ((ifid_uses_rs1 && ifid_rs1 == idex_rd) || (ifid_uses_rs2 && ifid_rs2 == idex_rd));
        run_drain = (m_mode == 3) ? ((m_drain > 0) ? m_drain - 1 : 0) : m_drain;
        if (r1)                begin run_o = O_MEM; run_mode = 1; end
        else if (r2)           begin run_o = O_MD;  run_mode = 2; end
        else if (branch_taken) begin run_o = O_BR;  run_mode = 0; end
        else if (r4)           begin run_o = O_BUB; run_mode = 3; run_drain = CSR_DRAIN - 1; end
        else if (r5)           begin run_o = O_BUB; run_mode = 0; end
        else                   begin run_o = O_RUN; run_mode = 0; end
        o = run_o; nmode = run_mode; ndrain = run_drain;
        if (reset) begin
            o = O_RST; nmode = 0; ndrain = 0;
        end else if (m_mode == 1 && !dmem_ready) begin
            o = O_MEM; nmode = 1;
        end else if (m_mode == 2 && !r1 && !muldiv_done) begin
            o = O_MD; nmode = 2;
        end else if (m_mode == 3 && r1) begin
            o = O_MEM; nmode = 3; ndrain = (m_drain > 0) ? m_drain - 1 : 0;
        end else if (m_mode == 3 && (m_drain > 0 || anyw)) begin
            o = O_BUB; nmode = 3; ndrain = m_drain - (m_drain > 0 ? 1 : 0);
        end
    endfunction

    always @(posedge clock) begin
        logic [7:0] o;
        int nm, nd;
        model_eval(o, nm, nd);
        m_mode  <= nm;
        m_drain <= nd;
        if (reset)
            m_stall <= 0;
        else if (!o[7] && m_stall < 64'h0000_0000_FFFF_FFFF)
            m_stall <= m_stall + 1;
    end

    always @(negedge clock) begin
        logic [7:0] o;
        int nm, nd;
        if (chk_en) begin
            model_eval(o, nm, nd);
            cmp("ctl_vector", {pc_write_en, ifid_write_en, idex_write_en, exmem_write_en,
                               ifid_flush, idex_flush, exmem_flush, memwb_flush}, o);
            cmp("ctrl_state", ctrl_state, m_mode);
            cmp("stall_cycles", stall_cycles, m_stall[31:0]);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_in();
        ifid_rs1 = 0; ifid_rs2 = 0; idex_rd = 0;
        ifid_uses_rs1 = 0; ifid_uses_rs2 = 0; ifid_csr_read = 0;
        idex_memread = 0; idex_muldiv = 0; muldiv_done = 0;
        idex_csr_write = 0; exmem_csr_write = 0; memwb_csr_write = 0;
        branch_taken = 0; dmem_req = 0; dmem_ready = 1;
    endtask

    // {req,rdy,muldiv,done,br,csr_rd,w_id,w_ex,w_wb,memread,u1,u2,match}
    logic [12:0] table_v [0:12] = '{
        13'b0_0_1_0_0_0_0_0_0_0_0_0_0,
        13'b1_0_1_0_0_0_0_0_0_0_0_0_0,
        13'b0_1_1_0_0_0_0_0_0_0_0_0_0,
        13'b0_1_1_1_0_1_1_0_0_0_0_0_0,
        13'b0_1_0_0_0_1_0_0_0_0_0_0_0,
        13'b0_1_0_0_0_1_0_0_1_0_0_0_0,
        13'b0_1_0_0_0_0_0_0_0_1_1_0_1,
        13'b1_1_0_0_1_0_0_0_0_1_1_0_1,
        13'b0_1_0_0_0_0_1_0_0_0_0_0_0,
        13'b0_1_0_0_0_1_0_1_0_1_0_1_1,
        13'b1_0_0_0_0_1_0_0_0_0_0_0_0,
        13'b1_0_0_0_0_1_0_0_0_0_0_0_0,
        13'b0_1_0_0_0_0_0_0_0_0_0_0_0
    };

    initial begin
        m_mode = 0; m_drain = 0; m_stall = 0;
        clear_in();
        reset = 1;
        @(negedge clock);
        cmp("reset_pc_we", pc_write_en, 0);
        cmp("reset_ifid_flush", ifid_flush, 1);
        cmp("reset_memwb_flush", memwb_flush, 1);
        tick(); chk_en = 1'b1;
        tick(); reset = 0;
        @(negedge clock);
        cmp("post_reset_state", ctrl_state, 0);
        cmp("post_reset_stall", stall_cycles, 0);
        cmp("post_reset_pc_we", pc_write_en, 1);
        tick();

        // Load-use on rs1, then rd=0, then rs2, then rs2 not used
        idex_memread = 1; idex_rd = 5; ifid_rs1 = 5; ifid_uses_rs1 = 1;
        @(negedge clock);
        cmp("lu_pc_we", pc_write_en, 0);
        cmp("lu_ifid_we", ifid_write_en, 0);
        cmp("lu_idex_flush", idex_flush, 1);
        tick(); clear_in();
        @(negedge clock); cmp("lu_after_pc_we", pc_write_en, 1); cmp("lu_after_stall", stall_cycles, 1);
        tick();
        idex_memread = 1; idex_rd = 0; ifid_rs1 = 0; ifid_uses_rs1 = 1;
        @(negedge clock); cmp("lu_rd0_pc_we", pc_write_en, 1);
        tick(); clear_in();
        idex_memread = 1; idex_rd = 7; ifid_rs2 = 7; ifid_uses_rs2 = 1;
        @(negedge clock); cmp("lu_rs2_pc_we", pc_write_en, 0);
        tick(); ifid_uses_rs2 = 0;
        @(negedge clock); cmp("lu_rs2_unused_pc_we", pc_write_en, 1);
        tick(); clear_in();

        // Data-memory wait, three cycles
        dmem_req = 1; dmem_ready = 0;
        @(negedge clock);
        cmp("mw_pc_we", pc_write_en, 0);
        cmp("mw_exmem_we", exmem_write_en, 0);
        cmp("mw_memwb_flush", memwb_flush, 1);
        tick();
        @(negedge clock); cmp("mw_state", ctrl_state, 1);
        tick(); tick(); dmem_ready = 1;
        @(negedge clock);
        cmp("mw_exit_pc_we", pc_write_en, 1);
        cmp("mw_exit_exmem_we", exmem_write_en, 1);
        cmp("mw_exit_stall", stall_cycles, 5);
        tick(); clear_in();
        @(negedge clock); cmp("mw_done_state", ctrl_state, 0);
        tick();

        // Mul/div completing on the fifth cycle
        idex_muldiv = 1;
        @(negedge clock);
        cmp("md_exmem_flush", exmem_flush, 1);
        cmp("md_exmem_we", exmem_write_en, 1);
        cmp("md_pc_we", pc_write_en, 0);
        tick();
        @(negedge clock); cmp("md_state", ctrl_state, 2);
        tick(); tick(); tick(); muldiv_done = 1;
        @(negedge clock);
        cmp("md_exit_pc_we", pc_write_en, 1);
        cmp("md_exit_stall", stall_cycles, 9);
        tick(); clear_in();
        @(negedge clock); cmp("md_done_state", ctrl_state, 0);
        tick();

        // Branch beats load-use
        branch_taken = 1; idex_memread = 1; idex_rd = 3; ifid_rs1 = 3; ifid_uses_rs1 = 1;
        @(negedge clock);
        cmp("br_pc_we", pc_write_en, 1);
        cmp("br_ifid_flush", ifid_flush, 1);
        cmp("br_idex_flush", idex_flush, 1);
        tick(); clear_in();
        @(negedge clock); cmp("br_after_pc_we", pc_write_en, 1); cmp("br_after_stall", stall_cycles, 9);
        tick();

        // CSR read-after-write: one-cycle write, then a write held four cycles
        ifid_csr_read = 1; exmem_csr_write = 1;
        @(negedge clock); cmp("csr_pc_we", pc_write_en, 0); cmp("csr_idex_flush", idex_flush, 1);
        tick(); exmem_csr_write = 0;
        @(negedge clock); cmp("csr_drain_pc_we", pc_write_en, 0); cmp("csr_state", ctrl_state, 3);
        tick();
        @(negedge clock); cmp("csr_exit_pc_we", pc_write_en, 1); cmp("csr_exit_stall", stall_cycles, 11);
        tick(); clear_in(); tick();
        ifid_csr_read = 1; memwb_csr_write = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock); cmp("csr_hold_pc_we", pc_write_en, 0);
            tick();
        end
        memwb_csr_write = 0;
        @(negedge clock); cmp("csr_hold_exit_pc_we", pc_write_en, 1); cmp("csr_hold_stall", stall_cycles, 15);
        tick(); clear_in(); tick();

        // Reset during MD_WAIT
        idex_muldiv = 1; tick(); tick();
        reset = 1;
        @(negedge clock);
        cmp("rst_md_pc_we", pc_write_en, 0);
        cmp("rst_md_exmem_flush", exmem_flush, 1);
        cmp("rst_md_ifid_flush", ifid_flush, 1);
        tick(); reset = 0; clear_in();
        @(negedge clock); cmp("rst_md_state", ctrl_state, 0); cmp("rst_md_stall", stall_cycles, 0);

        // Ten freeze cycles: narrow counter saturates at 7
        dmem_req = 1; dmem_ready = 0;
        repeat (10) tick();
        clear_in();
        @(negedge clock); cmp("sat_stall", s_stall, 7); cmp("wide_stall", stall_cycles, 10);
        tick();
        dmem_req = 1; dmem_ready = 0; tick(); tick(); clear_in();
        @(negedge clock); cmp("sat_hold", s_stall, 7); cmp("wide_stall2", stall_cycles, 12);
        tick();

        // Mixed-event table, checked by the model each cycle
        for (int i = 0; i < 13; i++) begin
            {dmem_req, dmem_ready, idex_muldiv, muldiv_done, branch_taken, ifid_csr_read,
             idex_csr_write, exmem_csr_write, memwb_csr_write, idex_memread,
             ifid_uses_rs1, ifid_uses_rs2} = table_v[i][12:1];
            idex_rd  = 5'd9;
            ifid_rs1 = table_v[i][0] ? 5'd9 : 5'd4;
            ifid_rs2 = table_v[i][0] ? 5'd9 : 5'd6;
            tick();
        end
        clear_in();
        repeat (3) tick();
        @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
